// File: rtl/rvv_backend_vrf_wb_sched.sv
// Write-back scheduler between the retire stage and the VRF write ports.
// Buffers multi-lane retire writes in a circular FIFO and drains index-disjoint runs to the VRF.
`ifndef NUM_RT_UOP
`define NUM_RT_UOP 4
`endif

package rvv_backend_vrf_wb_sched_pkg;
  localparam int VLEN  = 128;
  localparam int VLENB = VLEN / 8;
  localparam int REGW  = 5;

  typedef struct packed {
    logic [REGW-1:0]  rt_index;
    logic [VLEN-1:0]  rt_data;
    logic [VLENB-1:0] rt_strobe;
  } RT2VRF_t;
endpackage

module rvv_backend_vrf_wb_sched
  import rvv_backend_vrf_wb_sched_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LANES = `NUM_RT_UOP
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES-1:0]        wb_push_valid,
  input  RT2VRF_t [LANES-1:0]     wb_push_data,
  output logic [LANES-1:0]        wb_push_ready,
  output logic [LANES-1:0]        rt2vrf_wr_valid,
  output RT2VRF_t [LANES-1:0]     rt2vrf_wr_data,
  output logic [$clog2(DEPTH):0]  wb_count,
  output logic                    wb_empty
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;

  logic [PTRW-1:0] r_head;
  logic [PTRW-1:0] r_tail;
  logic [CNTW-1:0] r_count;
  RT2VRF_t         r_mem [DEPTH];

  logic [CNTW-1:0]     w_free;
  logic [CNTW-1:0]     w_push_cnt;
  logic [CNTW-1:0]     w_drain_cnt;
  logic [LANES-1:0]    w_push_en;
  RT2VRF_t [LANES-1:0] w_cand;

  assign w_free   = CNTW'(DEPTH) - r_count;
  assign wb_count = r_count;
  assign wb_empty = (r_count == '0);

  // Ready is a thermometer on free slots, so accepted lanes always form a prefix.
  always_comb begin : push_accept
    logic w_run;
    // NOTE: every signal written here is defaulted first so no path can leave it unassigned and infer a latch.
    wb_push_ready = '0;
    w_push_en     = '0;
    w_push_cnt    = '0;
    w_run         = 1'b1;
    for (int k = 0; k < LANES; k++) begin
      wb_push_ready[k] = (w_free > CNTW'(k));
      w_run            = w_run && wb_push_valid[k] && wb_push_ready[k];
      w_push_en[k]     = w_run;
      if (w_run) w_push_cnt = w_push_cnt + CNTW'(1);
    end
  end

  // Longest run from head that is occupied and never repeats an rt_index.
  always_comb begin : drain_select
    logic w_stop;
    w_stop      = 1'b0;
    w_drain_cnt = '0;
    for (int j = 0; j < LANES; j++) begin
      w_cand[j] = r_mem[r_head + PTRW'(j)];
    end
    for (int j = 0; j < LANES; j++) begin
      if (CNTW'(j) >= r_count) w_stop = 1'b1;
      for (int i = 0; i < j; i++) begin
        if (w_cand[i].rt_index == w_cand[j].rt_index) w_stop = 1'b1;
      end
      if (!w_stop) w_drain_cnt = w_drain_cnt + CNTW'(1);
    end
  end

  always_comb begin : drain_ports
    rt2vrf_wr_valid = '0;
    rt2vrf_wr_data  = '0;
    for (int j = 0; j < LANES; j++) begin
      if (CNTW'(j) < w_drain_cnt) begin
        rt2vrf_wr_valid[j] = 1'b1;
        rt2vrf_wr_data[j]  = w_cand[j];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTRW'(w_drain_cnt);
      r_tail  <= r_tail + PTRW'(w_push_cnt);
      r_count <= r_count + w_push_cnt - w_drain_cnt;
    end
  end

  // NOTE: entry storage is deliberately not reset; r_count alone decides which entries are live.
  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (w_push_en[k]) r_mem[r_tail + PTRW'(k)] <= wb_push_data[k];
    end
  end

endmodule

// File: doc/rvv_backend_vrf_wb_sched.md
RVV_BACKEND_VRF_WB_SCHED -- requirements
Module: rvv_backend_vrf_wb_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of write-back FIFO entries (power of 2, at least `NUM_RT_UOP).
REQ-002 SHALL have parameter LANES, default `NUM_RT_UOP (4): number of push lanes and VRF write ports.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-high.
REQ-005 wb_push_valid  input  LANES  per-lane write-back request.
REQ-006 wb_push_data  input  LANES x RT2VRF_t  per-lane request: rt_index, rt_data (VLEN), rt_strobe (VLENB).
REQ-007 wb_push_ready  output  LANES  per-lane acceptance.
REQ-008 rt2vrf_wr_valid  output  LANES  VRF write-port enables.
REQ-009 rt2vrf_wr_data  output  LANES x RT2VRF_t  VRF write-port payloads.
REQ-010 wb_count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-011 wb_empty  output  1  high when wb_count==0.

Function
REQ-012 SHALL buffer write-back requests in a circular FIFO (head pointer, tail pointer, count) and drain them to the VRF write ports in arrival order.
REQ-013 SHALL drive wb_push_ready[k] high iff DEPTH-wb_count >= k+1, using the registered count only, with no dependence on same-cycle pops.
REQ-014 SHALL accept lane k iff wb_push_valid[0..k] are all high and wb_push_ready[k] is high; lanes at and after the first low valid are ignored.
REQ-015 SHALL write accepted lanes to consecutive entries starting at tail, lane 0 first; tail advances by the accepted count modulo DEPTH.
REQ-016 SHALL choose the drain set as the longest run of valid entries from head, at most LANES entries, that stops before the first entry whose rt_index equals the rt_index of any earlier entry in the run.
REQ-017 SHALL present drain entry j on port j: rt2vrf_wr_valid[j]=1 and rt2vrf_wr_data[j] set to the entry contents. Ports at and beyond the drain count SHALL have valid=0 and data=0.
REQ-018 SHALL compute the drain set combinationally from registered FIFO state only. Push-to-write latency is therefore one cycle minimum, with no bypass.
REQ-019 SHALL pop every drained entry in the same cycle it is presented (the VRF always accepts); head advances by the drain count modulo DEPTH.
REQ-020 SHALL set next count = count + pushed - popped. Pushing and popping in the same cycle is legal at any occupancy, including full and empty.
REQ-021 SHALL guarantee that no two asserted ports in one cycle carry the same rt_index, so the VRF OR-merge never combines two writers.
REQ-022 SHALL drain a run of same-index entries one per cycle in FIFO order; the later write lands in a later cycle and wins.
REQ-023 SHALL handle pointer wrap-around transparently in both push and drain selection.
REQ-024 SHALL drive wb_count and wb_empty directly from registered state.

Reset
REQ-025 SHALL, on rst assertion, asynchronously clear head, tail and count to 0; buffered entries are discarded, including entries mid-drain.
REQ-026 SHALL hold these outputs during and immediately after reset: wb_push_ready all 1, rt2vrf_wr_valid all 0, rt2vrf_wr_data all 0, wb_count 0, wb_empty 1.
REQ-027 SHALL not require the entry storage to be reset; entry contents are qualified by count.

Verification
REQ-028 Push 4 lanes with indices 1,2,3,4 into an empty FIFO in cycle N -> no valid on any port in cycle N; in cycle N+1 all 4 ports valid with indices 1..4 in lane order, and wb_count returns to 0 in cycle N+2.
REQ-029 FIFO holds indices 5,5,6,7 from head -> cycle 1: port0 valid with index 5, others invalid; cycle 2: ports 0..2 valid with indices 5,6,7; strobes and data match the pushed values.
REQ-030 wb_count=6 with DEPTH=8 and no drain possible -> wb_push_ready=4'b0011; push 4 valid lanes -> only lanes 0,1 accepted, and wb_count=8 next cycle.
REQ-031 wb_push_valid=4'b1101 -> only lane 0 accepted, wb_count increments by exactly 1.
REQ-032 Fill to wrap-around (tail at 6, push 4 distinct indices) -> entries land in slots 6,7,0,1 and drain in push order over the following cycles.
REQ-033 Assert rst while 5 entries are buffered and ports are active -> rt2vrf_wr_valid drops to 0 asynchronously, wb_count=0, wb_empty=1; after release, the first push drains correctly.
